// File: rtl/trng_pkg.sv
// Shared defaults and helpers for the TRNG word packer and its FIFO.
package trng_pkg;

    localparam int WORD_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DROP_W_DEF     = 16;

    // FIFO pointers carry one extra wrap bit so full and empty differ only in the MSB.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module trng_sync_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] level
);

    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] FULL_XOR = {1'b1, {IDX_W{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head reads as zero when nothing is buffered, so stale storage never shows.
    assign rd_data = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

    // Pointer update; natural wrap of the extra bit gives modulo 2*DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write.
    // NOTE: storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/trng_word_packer.sv
// Packs the debiased bit stream MSB-first into words, buffers them in a FIFO
// behind a valid/ready handshake and counts words lost to back-pressure.
module trng_word_packer
    import trng_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DROP_W     = DROP_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic [WORD_W-1:0]            word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [ptr_w(FIFO_DEPTH)-1:0] fill_level,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         overflow,
    input  logic                         clear_status
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-2:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word_next;
    logic              accept;
    logic              last_bit;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;

    assign accept    = enable && bit_valid;
    assign last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
    assign word_next = {shift, bit_in};
    assign push      = accept && last_bit;
    assign pop       = word_valid && word_ready;
    assign word_valid = !empty;
    // A completed word is lost only if the FIFO is full and no slot frees this cycle.
    assign drop      = push && full && !pop;

    // Shift register and bit counter; disabling discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (!enable) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (bit_valid) begin
            if (last_bit) begin
                shift   <= '0;
                bit_cnt <= '0;
            end else begin
                shift   <= word_next[WORD_W-2:0];
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Saturating drop counter and sticky overflow; clear takes priority over a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_status) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            overflow <= 1'b1;
        end
    end

    trng_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .rd_data   (word_data),
        .full      (full),
        .empty     (empty),
        .level     (fill_level)
    );

endmodule

// File: tb/tb_trng_word_packer.sv
// Scoreboard bench for trng_word_packer: a default instance for packing and
// handshake behaviour plus a narrow instance for drop-counter saturation.
module tb_trng_word_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, bit_in, bit_valid, word_ready, clear_status;
    logic [7:0] word_data;
    logic       word_valid;
    logic [2:0] fill_level;
    logic [15:0] drop_count;
    logic       overflow;

    logic       s_enable, s_bit_in, s_bit_valid, s_ready, s_clear;
    logic [1:0] s_data;
    logic       s_valid;
    logic [1:0] s_fill;
    logic [3:0] s_drop;
    logic       s_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] drained[$];
    logic [7:0] m_word;
    int         m_cnt;
    int         m_drop;
    logic       m_ovf;

    always #5 clk = ~clk;

    trng_word_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fill_level   (fill_level),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .clear_status (clear_status)
    );

    trng_word_packer #(.WORD_W(2), .FIFO_DEPTH(2), .DROP_W(4)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (s_enable),
        .bit_in       (s_bit_in),
        .bit_valid    (s_bit_valid),
        .word_data    (s_data),
        .word_valid   (s_valid),
        .word_ready   (s_ready),
        .fill_level   (s_fill),
        .drop_count   (s_drop),
        .overflow     (s_ovf),
        .clear_status (s_clear)
    );

    task automatic model_reset();
        exp_q.delete();
        m_word = '0;
        m_cnt  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock: drive at the falling edge, update the model, compare at the next falling edge.
    task automatic cycle(input logic en, input logic bv, input logic b,
                         input logic rdy, input logic clr);
        logic       push_m, pop_m, full_m, drop_m;
        logic [7:0] w;
        logic [7:0] head;
        enable = en; bit_valid = bv; bit_in = b; word_ready = rdy; clear_status = clr;
        push_m = 1'b0;
        w      = '0;
        full_m = (exp_q.size() == 4);
        pop_m  = rdy && (exp_q.size() != 0);
        n_tests++;
        if (word_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL sb_valid: got %b want %b", word_valid, exp_q.size() != 0);
        end
        if (word_valid && rdy) drained.push_back(word_data);
        if (pop_m) begin
            head = exp_q.pop_front();
            n_tests++;
            if (word_data !== head) begin
                n_fail++;
                $display("FAIL sb_data: got %h want %h", word_data, head);
            end
        end
        if (!en) begin
            m_word = '0;
            m_cnt  = 0;
        end else if (bv) begin
            w = {m_word[6:0], b};
            if (m_cnt == 7) begin
                push_m = 1'b1;
                m_word = '0;
                m_cnt  = 0;
            end else begin
                m_word = w;
                m_cnt++;
            end
        end
        drop_m = push_m && full_m && !pop_m;
        if (push_m && !drop_m) exp_q.push_back(w);
        if (clr) begin
            m_drop = 0;
            m_ovf  = 1'b0;
        end else if (drop_m) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (drop_count !== 16'(m_drop) || overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL sb_drop: got %0d/%b want %0d/%b", drop_count, overflow, m_drop, m_ovf);
        end
    endtask

    task automatic feed_word(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) cycle(1'b1, 1'b1, w[i], rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic test_reset();
        enable = 0; bit_in = 0; bit_valid = 0; word_ready = 0; clear_status = 0;
        s_enable = 0; s_bit_in = 0; s_bit_valid = 0; s_ready = 0; s_clear = 0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: valid=%b data=%h fill=%0d want 0/00/0", word_valid, word_data, fill_level);
        end
        n_tests++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: drop=%0d ovf=%b want 0/0", drop_count, overflow);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        drained.delete();
        for (int i = 7; i >= 0; i--) cycle(1'b1, 1'b1, pat[i], 1'b1, 1'b0);
        n_tests++;
        if (word_valid !== 1'b1 || word_data !== 8'hB2) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b data=%h want 1/b2", word_valid, word_data);
        end
        idle(1, 1'b1);
        n_tests++;
        if (fill_level !== 3'd0 || word_valid !== 1'b0 || drained.size() != 1) begin
            n_fail++;
            $display("FAIL basic_drain: fill=%0d valid=%b popped=%0d want 0/0/1", fill_level, word_valid, drained.size());
        end
    endtask

    task automatic test_back_to_back();
        drained.delete();
        feed_word(8'hA5, 1'b0);
        feed_word(8'h3C, 1'b0);
        n_tests++;
        if (fill_level !== 3'd2 || word_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_fill: fill=%0d head=%h want 2/a5", fill_level, word_data);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b0);
            n_tests++;
            if (word_data !== 8'hA5 || word_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_hold: data=%h valid=%b want a5/1", word_data, word_valid);
            end
        end
        idle(3, 1'b1);
        n_tests++;
        if (drained.size() != 2 || drained[0] !== 8'hA5 || drained[1] !== 8'h3C || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_order: popped=%0d valid=%b want a5,3c then 0", drained.size(), word_valid);
        end
    endtask

    task automatic test_overflow();
        drained.delete();
        feed_word(8'h11, 1'b0);
        feed_word(8'h22, 1'b0);
        feed_word(8'h33, 1'b0);
        feed_word(8'h44, 1'b0);
        feed_word(8'h55, 1'b0);
        n_tests++;
        if (fill_level !== 3'd4 || drop_count !== 16'd1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: fill=%0d drop=%0d ovf=%b want 4/1/1", fill_level, drop_count, overflow);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: drop=%0d ovf=%b want 0/0", drop_count, overflow);
        end
        idle(5, 1'b1);
        n_tests++;
        if (drained.size() != 4 || drained[0] !== 8'h11 || drained[3] !== 8'h44 || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain: popped=%0d valid=%b want 11..44 only", drained.size(), word_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] w5;
        w5 = 8'h65;
        drained.delete();
        feed_word(8'h61, 1'b0);
        feed_word(8'h62, 1'b0);
        feed_word(8'h63, 1'b0);
        feed_word(8'h64, 1'b0);
        for (int i = 7; i >= 1; i--) cycle(1'b1, 1'b1, w5[i], 1'b0, 1'b0);
        cycle(1'b1, 1'b1, w5[0], 1'b1, 1'b0);
        n_tests++;
        if (fill_level !== 3'd4 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_full: fill=%0d drop=%0d ovf=%b want 4/0/0", fill_level, drop_count, overflow);
        end
        idle(5, 1'b1);
        n_tests++;
        if (drained.size() != 5 || drained[0] !== 8'h61 || drained[4] !== 8'h65) begin
            n_fail++;
            $display("FAIL pushpop_order: popped=%0d want 61..65", drained.size());
        end
    endtask

    task automatic test_enable_flush();
        drained.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        feed_word(8'hFF, 1'b1);
        idle(3, 1'b1);
        n_tests++;
        if (drained.size() != 1 || drained[0] !== 8'hFF || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_word: popped=%0d fill=%0d want one ff, fill 0", drained.size(), fill_level);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'h5A;
        drained.delete();
        feed_word(8'h71, 1'b0);
        feed_word(8'h72, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (word_valid !== 1'b0 || word_data !== 8'h00 || fill_level !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_async: valid=%b data=%h fill=%0d want 0/00/0", word_valid, word_data, fill_level);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            cycle(1'b1, 1'b1, w[i], 1'b0, 1'b0);
            n_tests++;
            if (word_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_early: valid=%b after %0d bits want 0", word_valid, 8 - i);
            end
        end
        cycle(1'b1, 1'b1, w[0], 1'b0, 1'b0);
        n_tests++;
        if (word_valid !== 1'b1 || word_data !== 8'h5A || fill_level !== 3'd1) begin
            n_fail++;
            $display("FAIL midreset_fresh: valid=%b data=%h fill=%0d want 1/5a/1", word_valid, word_data, fill_level);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_saturation();
        s_enable = 1'b1; s_bit_valid = 1'b1; s_ready = 1'b0; s_clear = 1'b0;
        // two words fill the depth-2 FIFO, then every two bits is one drop
        for (int i = 0; i < 24; i++) begin
            s_bit_in = i[0];
            @(negedge clk);
        end
        n_tests++;
        if (s_drop !== 4'd10 || s_ovf !== 1'b1 || s_fill !== 2'd2) begin
            n_fail++;
            $display("FAIL sat_count: drop=%0d ovf=%b fill=%0d want 10/1/2", s_drop, s_ovf, s_fill);
        end
        for (int i = 0; i < 18; i++) begin
            s_bit_in = i[0];
            @(negedge clk);
        end
        n_tests++;
        if (s_drop !== 4'hF || s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ceiling: drop=%0d ovf=%b want 15/1", s_drop, s_ovf);
        end
        s_bit_in = 1'b1;
        @(negedge clk);
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        s_bit_valid = 1'b0;
        n_tests++;
        if (s_drop !== 4'd0 || s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear_wins: drop=%0d ovf=%b want 0/0", s_drop, s_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_enable_flush();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
